// File: rtl/score_update_arbiter_pkg.sv
// score_update_arbiter_pkg: FSM state encoding shared by the score arbiter files.
package score_update_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;
endpackage

// File: rtl/score_pending_counter.sv
// score_pending_counter: saturating per-source point counter with a sticky drop flag.
module score_pending_counter #(
  parameter int PEND_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  output logic [PEND_WIDTH-1:0] count,
  output logic                  overflow
);
  logic sat;
  assign sat = &count;
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= (inc && !dec && !sat) ? count + 1'b1 : (dec && !inc) ? count - 1'b1 : count;
      if (inc && !dec && sat) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/score_update_arbiter.sv
// score_update_arbiter: round-robin sharing of one UpdateScore among NUM_REQ point sources.
// Define SCORE_ARB_TIMEOUT_EN to abort a handshake after TIMEOUT_CYCLES waiting cycles.
module score_update_arbiter
  import score_update_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PEND_WIDTH     = 4,
`ifdef SCORE_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1024,
`endif
  parameter int GRANT_WIDTH    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic                   score_ready,
  output logic                   score_enable,
  output logic [GRANT_WIDTH-1:0] grant_id,
  output logic                   busy,
  output logic                   pending_any,
  output logic [NUM_REQ-1:0]     overflow,
  output logic                   timeout
);
  state_t                 state;
  logic [GRANT_WIDTH-1:0] start_ptr, pick, cand, next_ptr;
  logic [NUM_REQ-1:0]     nz, dec;
  logic [PEND_WIDTH-1:0]  count [NUM_REQ];
  logic                   go, abort;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    score_pending_counter #(.PEND_WIDTH(PEND_WIDTH)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .inc      (req[i]),
      .dec      (dec[i]),
      .count    (count[i]),
      .overflow (overflow[i])
    );
    assign nz[i]  = |count[i];
    assign dec[i] = go && pick == GRANT_WIDTH'(i);
  end
  assign pending_any = |nz;
  assign go          = state == IDLE && pending_any && score_ready;
  assign next_ptr    = GRANT_WIDTH'((int'(grant_id) + 1) % NUM_REQ);
  // Walk from the far end so the nearest nonzero source after start_ptr wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = GRANT_WIDTH'((int'(start_ptr) + k) % NUM_REQ);
      if (nz[cand]) pick = cand;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      score_enable <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      start_ptr    <= '0;
    end else begin
      score_enable <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state        <= ISSUE;
          score_enable <= 1'b1;
          busy         <= 1'b1;
          grant_id     <= pick;
        end
        ISSUE:    state <= WAIT_LOW;
        WAIT_LOW: if (!score_ready) state <= WAIT_HIGH;
        WAIT_HIGH: if (score_ready) begin
          state     <= IDLE;
          busy      <= 1'b0;
          start_ptr <= next_ptr;
        end
      endcase
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        start_ptr <= next_ptr;
      end
    end
  end
`ifdef SCORE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  assign abort = (state == WAIT_LOW || state == WAIT_HIGH) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= state == ISSUE ? '0 : state == IDLE ? tcnt : tcnt + 1'b1;
      if (abort) timeout <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_score_update_arbiter.sv
// tb_score_update_arbiter: directed tests plus an every-cycle round-robin model check.
module tb_score_update_arbiter;
  localparam int N = 4;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         score_ready = 1'b1;
  logic         score_enable, busy, pending_any, timeout;
  logic [1:0]   grant_id;
  logic [N-1:0] overflow;
  int           checks = 0, passes = 0;
  int           mode = 0;
  int           n_en = 0;
  int           gq[$];
  int           pend[N];
  logic [N-1:0] ovf = '0;
  int           last = N - 1;
  int           last_en = -100;
  int           cyc = 0;

  always #5 clock = ~clock;

  score_update_arbiter #(
`ifdef SCORE_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES (16),
`endif
    .NUM_REQ        (N),
    .PEND_WIDTH     (4),
    .GRANT_WIDTH    (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .score_ready  (score_ready),
    .score_enable (score_enable),
    .grant_id     (grant_id),
    .busy         (busy),
    .pending_any  (pending_any),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int pick_m();
    for (int k = 1; k <= N; k++)
      if (pend[(last + k) % N] > 0) return (last + k) % N;
    return -1;
  endfunction

  // UpdateScore stand-in: mode 0 normal handshake, 1 ready held low, 2 ready stuck high
  initial begin
    int   since = 100;
    logic rs;
    forever begin
      @(posedge clock);
      rs = reset;
      #1;
      since = rs ? 100 : score_enable ? 0 : (since < 100 ? since + 1 : since);
      score_ready = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : !(since >= 1 && since <= 3);
    end
  end

  // Model: pending counts per source, last granted source, spacing of enables
  initial begin
    logic [N-1:0] r;
    logic         rs;
    int           g;
    bit           any;
    forever begin
      @(posedge clock);
      r  = req;
      rs = reset;
      cyc++;
      @(negedge clock);
      if (rs) begin
        foreach (pend[i]) pend[i] = 0;
        ovf = '0;
        last = N - 1;
        last_en = -100;
        chk("rst_enable", score_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending_any", pending_any, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_grant_id", grant_id, 0);
      end else begin
        if (score_enable) begin
          g = pick_m();
          chk("model_grant_id", grant_id, g);
          chk("model_busy_at_enable", busy, 1);
          chk("model_enable_gap", (cyc - last_en) >= 4, 1);
          if (g >= 0) begin
            pend[g]--;
            last = g;
          end
          last_en = cyc;
          n_en++;
          gq.push_back(int'(grant_id));
        end
        any = 0;
        for (int i = 0; i < N; i++) begin
          if (r[i]) begin
            if (pend[i] == 15) ovf[i] = 1'b1;
            else pend[i]++;
          end
          if (pend[i] != 0) any = 1;
        end
        chk("model_pending_any", pending_any, any);
        chk("model_overflow", overflow, ovf);
`ifndef SCORE_ARB_TIMEOUT_EN
        chk("model_timeout_tied", timeout, 0);
`endif
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    @(posedge clock); #1 req = v;
    @(posedge clock); #1 req = '0;
  endtask

  task automatic wait_en(input int lim, output bit ok);
    ok = 0;
    repeat (lim) begin
      @(negedge clock);
      if (score_enable) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int e0, q0;
    bit ok;
    int exp3[5] = '{0, 1, 2, 3, 2};
    // 1: reset held two cycles
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("t1_enable", score_enable, 0);
    chk("t1_busy", busy, 0);
    chk("t1_grant_id", grant_id, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_timeout", timeout, 0);
    @(posedge clock); #1 reset = 1'b0;
    // 2: single point, exact latency
    do_reset();
    @(posedge clock); #1 req = 4'b0001;
    @(posedge clock); #1 req = '0;
    @(negedge clock);
    chk("t2_enable_t1", score_enable, 0);
    chk("t2_pending_t1", pending_any, 1);
    @(negedge clock);
    chk("t2_enable_t2", score_enable, 1);
    chk("t2_grant_t2", grant_id, 0);
    chk("t2_busy_t2", busy, 1);
    @(negedge clock);
    chk("t2_enable_t3", score_enable, 0);
    chk("t2_pending_t3", pending_any, 0);
    repeat (10) @(posedge clock);
    // 3: round-robin order 0,1,2,3 then 2
    do_reset();
    q0 = gq.size();
    pulse(4'b1111);
    ok = 0;
    repeat (60) begin
      @(posedge clock);
      if (gq.size() >= q0 + 4) begin
        ok = 1;
        break;
      end
    end
    chk("t3_four_grants", ok, 1);
    #1 req = 4'b0100;
    @(posedge clock); #1 req = '0;
    ok = 0;
    repeat (30) begin
      @(posedge clock);
      if (gq.size() >= q0 + 5) begin
        ok = 1;
        break;
      end
    end
    chk("t3_fifth_grant", ok, 1);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t3_grant%0d", k), gq.size() > q0 + k ? gq[q0 + k] : -1, exp3[k]);
    repeat (10) @(posedge clock);
    // 4: saturation while ready held low, then drain
    do_reset();
    @(negedge clock);
    mode = 1;
    repeat (3) @(posedge clock);
    e0 = n_en;
    repeat (20) pulse(4'b0010);
    @(negedge clock);
    chk("t4_overflow", overflow, 4'b0010);
    chk("t4_no_enable_while_low", n_en - e0, 0);
    chk("t4_pending", pending_any, 1);
    mode = 0;
    ok = 0;
    repeat (200) begin
      @(negedge clock);
      if (!busy && !pending_any) begin
        ok = 1;
        break;
      end
    end
    chk("t4_drained", ok, 1);
    chk("t4_enables", n_en - e0, 15);
    // 5: ready never drops after enable
    do_reset();
    @(negedge clock);
    mode = 2;
    pulse(4'b0001);
    wait_en(10, ok);
    chk("t5_enable", ok, 1);
`ifdef SCORE_ARB_TIMEOUT_EN
    repeat (16) @(negedge clock);
    chk("t5_timeout_early", timeout, 0);
    chk("t5_busy_early", busy, 1);
    @(negedge clock);
    chk("t5_timeout", timeout, 1);
    chk("t5_idle", busy, 0);
    repeat (5) @(negedge clock);
    chk("t5_timeout_sticky", timeout, 1);
`else
    repeat (40) @(negedge clock);
    chk("t5_busy_stuck", busy, 1);
    chk("t5_timeout_zero", timeout, 0);
`endif
    // 6: reset while in WAIT_HIGH with three points pending
    do_reset();
    @(negedge clock);
    mode = 0;
    pulse(4'b1111);
    wait_en(10, ok);
    chk("t6_enable", ok, 1);
    @(negedge clock);
    chk("t6_busy_before", busy, 1);
    chk("t6_pending_before", pending_any, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t6_busy_after", busy, 0);
    chk("t6_pending_after", pending_any, 0);
    chk("t6_enable_after", score_enable, 0);
    e0 = n_en;
    repeat (20) @(negedge clock);
    chk("t6_no_enables", n_en - e0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
